// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS32 data-memory responder and the controller-side stall logic.
// Pure declarations: no latency, no flow control.
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mips_mem_array.sv
// Word storage with a byte-enabled write port and a registered read port (1 cycle).
// Read output returns to 0 whenever no read is issued; no flow control.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder: captures one request, ack WAIT_CYCLES+1 cycles later; inputs ignored while busy.
// MIPS_MEM_ERR_EN enables misalignment/range errors; without it err is 0 and addresses wrap.
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state;
    logic [3:0]  cnt;
    mem_req_t    req_q;
    mem_req_t    cur;
    logic [31:0] offset;
    logic [AW-1:0] cur_idx;
    logic        bad;
    logic        enter_resp;
    logic        unused_offset_bits;

    // In IDLE the live inputs are the request (needed when WAIT_CYCLES=0); otherwise the held copy.
    always_comb begin
        cur        = (state == IDLE) ? '{we: we, addr: addr, wdata: wdata, be: be} : req_q;
        offset     = cur.addr - ADDR_BASE;
        cur_idx    = offset[AW+1:2];
`ifdef MIPS_MEM_ERR_EN
        bad        = (cur.addr[1:0] != 2'b00) || (offset >= SPAN);
`else
        bad        = 1'b0;
`endif
        enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));
    end

    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            req_q <= '0;
        end else begin
            ack <= enter_resp;
            err <= enter_resp & bad;
            case (state)
                IDLE: begin
                    if (req) begin
                        req_q <= cur;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Store commits on the edge that ends RESP; err already holds this request's range verdict.
    mips_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (rst && (state == RESP) && req_q.we && !err),
        .wr_idx (cur_idx),
        .wr_data(req_q.wdata),
        .wr_be  (req_q.be),
        .rd_en  (enter_resp && !cur.we && !bad),
        .rd_idx (cur_idx),
        .rd_data(rdata)
    );

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Bench: two responders (2 and 0 wait states) driven by directed and random transactions,
// checked against a word-array reference model.
module tb_mips_data_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
`ifdef MIPS_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    logic [31:0] mem_m [2][DEPTH];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_BASE(BASE)) u_w2 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .be(be[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0])
    );

    mips_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(BASE)) u_w0 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .be(be[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int waits_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % 32'(DEPTH));
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return ERR_EN && ((a[1:0] != 2'b00) || (off >= SPAN));
    endfunction

    // One transaction; chained=1 means req is still high from the previous ack and simply changes.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input bit chained, input string tag);
        logic [31:0] exp_rd;
        int idx, lat;
        bit bad;
        bad    = is_bad(a);
        idx    = widx(a);
        exp_rd = (!w && !bad) ? mem_m[d][idx] : 32'h0;
        if (w && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (!chained) begin
            req[d] = 1'b0;
            @(negedge clk);
            chk({tag, "_idle_ack"}, 32'(ack[d]), 32'h0);
            chk({tag, "_idle_rdata"}, rdata[d], 32'h0);
        end
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack[d] !== 1'b1 && lat < 40);
        chk({tag, "_lat"}, 32'(lat), 32'(waits_of(d) + 1 + (chained ? 1 : 0)));
        chk({tag, "_rdata"}, rdata[d], exp_rd);
        chk({tag, "_err"}, 32'(err[d]), 32'(bad));
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack", 32'(ack[d]), 32'h0);
            chk("rst_rdata", rdata[d], 32'h0);
            chk("rst_err", 32'(err[d]), 32'h0);
        end
        rst = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                txn(d, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 1'b0, "preload");
            end
            txn(d, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "st_beef");
            txn(d, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0, "ld_beef");
            txn(d, 1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 1'b0, "st_base");
            txn(d, 1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "st_be0101");
            txn(d, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, "ld_be0101");
            txn(d, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, "st_be0000");
            txn(d, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, "ld_be0000");
            txn(d, 1'b1, BASE + 32'h24, 32'h0BADF00D, 4'hF, 1'b0, "st_chain");
            txn(d, 1'b0, BASE + 32'h24, 32'h0, 4'hF, 1'b1, "ld_chain");
            txn(d, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, "ld_chain2");
            txn(d, 1'b0, BASE + 32'h3, 32'h0, 4'hF, 1'b0, "ld_misalign");
            txn(d, 1'b1, BASE + SPAN, 32'hCAFEF00D, 4'hF, 1'b0, "st_oor");
            txn(d, 1'b0, BASE, 32'h0, 4'hF, 1'b0, "ld_word0");
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 9))
                    0:       a = BASE + SPAN + 32'(4 * $urandom_range(0, 3));
                    1:       a = BASE - 32'h4;
                    2:       a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                    default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                endcase
                txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    (n > 0) && ($urandom_range(0, 2) == 0), "rand");
            end
            req[d] = 1'b0;
        end

        // Abort a store during its wait states on the 2-wait instance.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'h8; wdata[0] = 32'h5; be[0] = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req[0] = 1'b0;
        chk("abort_ack", 32'(ack[0]), 32'h0);
        chk("abort_rdata", rdata[0], 32'h0);
        chk("abort_err", 32'(err[0]), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_ack", 32'(ack[0]), 32'h0);
        txn(0, 1'b0, BASE + 32'h8, 32'h0, 4'hF, 1'b0, "ld_after_abort");
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
